// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame packer: sample width, header magic,
// FSM state encoding and the header word layout.
package audio_pkg;

  localparam int          SAMPLE_W       = 32;
  localparam logic [15:0] HDR_MAGIC_DFLT = 16'hA55A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } pack_state_e;

  function automatic logic [SAMPLE_W-1:0] make_hdr(input logic [15:0] magic,
                                                   input logic [15:0] seq);
    return {magic, seq};
  endfunction

endpackage

// File: rtl/audio_sync_fifo.sv
// First-word-fall-through synchronous FIFO for 32-bit audio samples;
// rd_data always shows the head word while the FIFO is not empty.
module audio_sync_fifo
  import audio_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                aud_bclk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [AW:0]         level,
  output logic                full,
  output logic                empty
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                wr_ok;
  logic                rd_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge aud_bclk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_frame_pack.sv
// Packs receiver samples into fixed-length frames (header + PKT_WORDS samples,
// L first) on a valid/ready stream, with overflow drop counting.
//
// state  | meaning
// S_IDLE | waiting for a full frame of samples in the FIFO
// S_HDR  | presenting header {HDR_MAGIC, seq}
// S_DATA | streaming FIFO words; eop on the last one
module audio_frame_pack
  import audio_pkg::*;
#(
  parameter  int          PKT_WORDS = 256,
  parameter  int          DEPTH     = 1024,
  parameter  logic [15:0] HDR_MAGIC = HDR_MAGIC_DFLT,
  localparam int          AW        = $clog2(DEPTH),
  localparam int          CW        = $clog2(PKT_WORDS) + 1
) (
  input  logic                aud_bclk,
  input  logic                rst,
  input  logic                rx_done,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                aud_lrc,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_sop,
  output logic                out_eop,
  input  logic                out_ready,
  output logic [15:0]         drop_cnt,
  output logic [AW:0]         fifo_level
);

  pack_state_e         state;
  logic                synced;
  logic                accept;
  logic                wr_en;
  logic                drop;
  logic                rd_en;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic [SAMPLE_W-1:0] hdr_q;
  logic [CW-1:0]       word_cnt;
  logic [15:0]         seq;

  // Right samples are ignored until a left one re-establishes L,R order.
  assign accept = rx_done && (synced || !aud_lrc);
  assign wr_en  = accept && !fifo_full;
  assign drop   = accept && fifo_full;
  assign rd_en  = (state == S_DATA) && out_valid && out_ready && !fifo_empty;

  assign out_data = (state == S_DATA) ? fifo_head : hdr_q;

  audio_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aud_bclk (aud_bclk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (adc_data),
    .rd_en    (rd_en),
    .rd_data  (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      synced   <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      synced <= 1'b0;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (wr_en) begin
      synced <= 1'b1;
    end
  end

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      hdr_q     <= '0;
      word_cnt  <= '0;
      seq       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_level >= (AW+1)'(PKT_WORDS)) state <= S_HDR;
        end
        S_HDR: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sop   <= 1'b1;
            hdr_q     <= make_hdr(HDR_MAGIC, seq);
          end else if (out_ready) begin
            out_sop  <= 1'b0;
            hdr_q    <= '0;
            word_cnt <= '0;
            out_eop  <= (PKT_WORDS == 1);
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (out_ready) begin
            if (out_eop) begin
              out_valid <= 1'b0;
              out_eop   <= 1'b0;
              seq       <= seq + 16'd1;
              state     <= S_IDLE;
            end else begin
              word_cnt <= word_cnt + CW'(1);
              // eop is registered, so raise it one word ahead of the last.
              out_eop  <= (word_cnt == CW'(PKT_WORDS - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
